// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the FIR core: replays a valid/ready coefficient stream as an
// ordered RAM write sequence and gates the 600 kHz sample tick while an update runs.
module fir_coeff_loader #(
    parameter int NUM_COEFF  = 40,
    parameter int DIV        = 20,
    parameter int DATA_WIDTH = 16,
    parameter int DRAIN_CYC  = 2
) (
    input  logic                  iClk12M,
    input  logic                  iRsn,
    input  logic                  iStart,
    input  logic                  iCoeffValid,
    input  logic [DATA_WIDTH-1:0] iCoeffData,
    output logic                  oCoeffReady,
    output logic                  oCoeffUpdateFlag,
    output logic [5:0]            oAddrRam,
    output logic [DATA_WIDTH-1:0] oWrDtRam,
    output logic [5:0]            oNumOfCoeff,
    output logic                  oEnSample600k,
    output logic                  oBusy,
    output logic                  oDone
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        LOAD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DRW  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [5:0]      LAST_BEAT  = 6'(NUM_COEFF - 1);
    localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(DIV - 1);
    localparam logic [DRW-1:0]  DRAIN_LAST = DRW'(DRAIN_CYC - 1);

    state_t          state_r;
    logic [5:0]      beatCnt_r;
    logic [DRW-1:0]  drainCnt_r;
    logic [DIVW-1:0] divCnt_r;
    logic            beatAccept_s;

    assign oCoeffReady  = (state_r == LOAD);
    assign oNumOfCoeff  = 6'(NUM_COEFF);
    assign beatAccept_s = oCoeffReady & iCoeffValid;

    // Free-running sample divider; ticks are dropped (not deferred) outside IDLE.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            divCnt_r      <= {DIVW{1'b0}};
            oEnSample600k <= 1'b0;
        end else begin
            divCnt_r      <= (divCnt_r == DIV_LAST) ? {DIVW{1'b0}} : divCnt_r + DIVW'(1);
            oEnSample600k <= (divCnt_r == DIV_LAST) && (state_r == IDLE);
        end
    end

    // Load sequencer with registered flag/busy/done and RAM write port.
    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_r          <= IDLE;
            beatCnt_r        <= 6'd0;
            drainCnt_r       <= {DRW{1'b0}};
            oCoeffUpdateFlag <= 1'b0;
            oBusy            <= 1'b0;
            oDone            <= 1'b0;
            oAddrRam         <= 6'd0;
            oWrDtRam         <= {DATA_WIDTH{1'b0}};
        end else begin
            oDone <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (iStart) begin
                        state_r          <= ARM;
                        oCoeffUpdateFlag <= 1'b1;
                        oBusy            <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARM: begin
                    state_r <= LOAD;
                end
                LOAD: begin
                    if (beatAccept_s) begin
                        oAddrRam <= beatCnt_r;
                        oWrDtRam <= iCoeffData;
                        if (beatCnt_r == LAST_BEAT) begin
                            state_r    <= DRAIN;
                            drainCnt_r <= {DRW{1'b0}};
                        end else begin
                            beatCnt_r <= beatCnt_r + 6'd1;
                        end
                    end else begin
                        state_r <= LOAD;
                    end
                end
                DRAIN: begin
                    // Flag stays up until the FIR has had DRAIN_CYC cycles to absorb the last write.
                    if (drainCnt_r == DRAIN_LAST) begin
                        state_r          <= IDLE;
                        oCoeffUpdateFlag <= 1'b0;
                        oBusy            <= 1'b0;
                        oDone            <= 1'b1;
                        beatCnt_r        <= 6'd0;
                    end else begin
                        drainCnt_r <= drainCnt_r + DRW'(1);
                    end
                end
                default: begin
                    state_r          <= IDLE;
                    oCoeffUpdateFlag <= 1'b0;
                    oBusy            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized self-checking bench for fir_coeff_loader against a cycle-level behavioural model.
module tb_fir_coeff_loader;

    localparam int NC  = 40;
    localparam int DV  = 20;
    localparam int DRN = 2;

    logic        iClk12M = 1'b0;
    logic        iRsn, iStart, iCoeffValid;
    logic [15:0] iCoeffData;
    logic        oCoeffReady, oCoeffUpdateFlag, oEnSample600k, oBusy, oDone;
    logic [5:0]  oAddrRam, oNumOfCoeff;
    logic [15:0] oWrDtRam;

    int nCmp = 0;
    int nErr = 0;

    // Model: mPhase 0=idle 1=arm 2=load 3=drain
    int          mPhase, mBeats, mDrainLeft, mEdge;
    logic [5:0]  mAddr;
    logic [15:0] mData;
    logic        mTick, mDone;

    fir_coeff_loader #(.NUM_COEFF(NC), .DIV(DV), .DATA_WIDTH(16), .DRAIN_CYC(DRN)) dut (
        .iClk12M(iClk12M), .iRsn(iRsn), .iStart(iStart), .iCoeffValid(iCoeffValid),
        .iCoeffData(iCoeffData), .oCoeffReady(oCoeffReady), .oCoeffUpdateFlag(oCoeffUpdateFlag),
        .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam), .oNumOfCoeff(oNumOfCoeff),
        .oEnSample600k(oEnSample600k), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk12M = ~iClk12M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = 0; mBeats = 0; mDrainLeft = 0; mEdge = 0;
        mAddr = 6'd0; mData = 16'd0; mTick = 1'b0; mDone = 1'b0;
    endtask

    task automatic modelEdge(input bit st, input bit vld, input logic [15:0] d);
        mEdge++;
        mTick = ((mEdge % DV) == 0) && (mPhase == 0);
        mDone = 1'b0;
        if (mPhase == 0) begin
            if (st) mPhase = 1;
        end else if (mPhase == 1) begin
            mPhase = 2;
        end else if (mPhase == 2) begin
            if (vld) begin
                mAddr = 6'(mBeats);
                mData = d;
                mBeats++;
                if (mBeats == NC) begin
                    mPhase = 3;
                    mDrainLeft = DRN;
                end
            end
        end else begin
            mDrainLeft--;
            if (mDrainLeft == 0) begin
                mPhase = 0; mDone = 1'b1; mBeats = 0;
            end
        end
    endtask

    task automatic cycle(input bit st, input bit vld, input logic [15:0] d);
        iStart = st; iCoeffValid = vld; iCoeffData = d;
        @(posedge iClk12M);
        modelEdge(st, vld, d);
        #1;
        chk("ready", oCoeffReady, mPhase == 2);
        chk("flag",  oCoeffUpdateFlag, mPhase != 0);
        chk("busy",  oBusy, mPhase != 0);
        chk("addr",  oAddrRam, mAddr);
        chk("data",  oWrDtRam, mData);
        chk("tick",  oEnSample600k, mTick);
        chk("done",  oDone, mDone);
    endtask

    task automatic runLoad(input int period, input bit spamStart, input bit atTick);
        int flagCyc, dones, c;
        bit vld;
        flagCyc = 0; dones = 0; c = 0;
        if (atTick) begin
            while (((mEdge + 1) % DV) != 0) cycle(1'b0, 1'b0, 16'd0);
        end
        cycle(1'b1, 1'b0, 16'd0);
        if (atTick) begin
            chk("tickOnStart", oEnSample600k, 1'b1);
            chk("armOnStart", oBusy, 1'b1);
        end
        if (oCoeffUpdateFlag) flagCyc++;
        while (dones == 0 && c < 600) begin
            vld = ((c % period) == 0);
            cycle(spamStart ? 1'($urandom_range(0, 1)) : 1'b0, vld,
                  (period == 1) ? 16'(16'h1000 + mBeats) : 16'($urandom));
            if (oCoeffUpdateFlag) flagCyc++;
            if (oDone) dones++;
            c++;
        end
        chk("loadTimeout", c < 600, 1'b1);
        repeat (3) begin
            cycle(1'b0, 1'b0, 16'd0);
            if (oDone) dones++;
        end
        chk("doneCount", dones, 1);
        if (period == 1) chk("flagCycles", flagCyc, 1 + NC + DRN);
    endtask

    initial begin
        iRsn = 1'b0; iStart = 1'b0; iCoeffValid = 1'b0; iCoeffData = 16'd0;
        repeat (2) @(posedge iClk12M);
        #1 iRsn = 1'b1;
        modelReset();
        chk("rstReady", oCoeffReady, 1'b0);
        chk("rstFlag", oCoeffUpdateFlag, 1'b0);
        chk("rstAddr", oAddrRam, 6'd0);
        chk("rstData", oWrDtRam, 16'd0);
        chk("rstTick", oEnSample600k, 1'b0);
        chk("rstBusy", oBusy, 1'b0);
        chk("rstDone", oDone, 1'b0);
        chk("numCoeff", oNumOfCoeff, 6'd40);

        // idle ticks: first at edge 20, then every 20
        repeat (45) cycle(1'b0, 1'b0, 16'd0);

        runLoad(1, 1'b0, 1'b0);   // back-to-back beats
        runLoad(3, 1'b0, 1'b0);   // valid every third cycle
        runLoad(2, 1'b1, 1'b0);   // start spammed during load
        runLoad(1, 1'b0, 1'b1);   // start coincident with tick

        // mid-load reset after 17 beats
        cycle(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 100 && mBeats < 17; i++) cycle(1'b0, 1'b1, 16'($urandom));
        chk("beatsBeforeRst", mBeats, 17);
        iRsn = 1'b0;
        #1;
        chk("midRstFlag", oCoeffUpdateFlag, 1'b0);
        chk("midRstReady", oCoeffReady, 1'b0);
        chk("midRstBusy", oBusy, 1'b0);
        chk("midRstAddr", oAddrRam, 6'd0);
        repeat (2) @(posedge iClk12M);
        #1 iRsn = 1'b1;
        modelReset();
        runLoad(1, 1'b0, 1'b0);

        // valid in idle without start is ignored
        repeat (30) cycle(1'b0, 1'b1, 16'($urandom));

        // random mix
        repeat (400) cycle($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Writer side of the FIR coefficient-update and sample-strobe interface. The block accepts a stream of 16-bit coefficients over a valid/ready handshake and replays them as an ordered address/data write sequence on the FIR core's update port (update flag, RAM address, RAM write data, coefficient count). It also generates the 600 kHz sample-enable tick from the 12 MHz clock and suppresses that tick for the whole update, so the FIR never filters with a partially written coefficient set. It sits between the host/config logic and the FIR top.

## Interface
- NUM_COEFF, 40, coefficients per update (1..63); also driven on oNumOfCoeff
- DIV, 20, clock cycles per sample tick (12 MHz / 600 kHz)
- DATA_WIDTH, 16, coefficient width
- DRAIN_CYC, 2, cycles the flag stays high after the last write
- iClk12M  in  1  system clock, 12 MHz
- iRsn  in  1  reset; one clock; reset is asynchronous and active-low
- iStart  in  1  single-cycle request to begin a coefficient load
- iCoeffValid  in  1  upstream coefficient valid
- iCoeffData  in  DATA_WIDTH  upstream coefficient, sent in address order 0..NUM_COEFF-1
- oCoeffReady  out  1  loader accepts a beat this cycle
- oCoeffUpdateFlag  out  1  update in progress; drives FIR iCoeffUpdateFlag
- oAddrRam  out  6  coefficient address; drives FIR iAddrRam
- oWrDtRam  out  DATA_WIDTH  coefficient value; drives FIR iWrDtRam
- oNumOfCoeff  out  6  constant NUM_COEFF
- oEnSample600k  out  1  one-cycle sample tick; drives FIR iEnSample600k
- oBusy  out  1  state != IDLE
- oDone  out  1  one-cycle pulse when a load completes

## Operation
- FSM states: IDLE, ARM, LOAD, DRAIN.
- IDLE: oCoeffReady=0. If iStart=1, go to ARM. iCoeffValid is ignored.
- ARM: lasts 1 cycle; flag goes high; go to LOAD.
- LOAD: oCoeffReady=1 (combinational from state). Each beat (valid & ready) registers oAddrRam=beat index and oWrDtRam=iCoeffData, then increments the beat counter.
  - Between beats, addr/data hold their last values. The FIR rewrites the same value, which is harmless by contract.
  - When beat NUM_COEFF-1 is accepted, go to DRAIN.
- DRAIN: oCoeffReady=0; flag held high for DRAIN_CYC cycles. Then go to IDLE: flag low, oDone pulses for 1 cycle, beat counter cleared.
- iStart outside IDLE is ignored (no queuing).
- Sample divider: counter runs 0..DIV-1 and wraps. It runs continuously, independent of FSM state. oEnSample600k = (count==DIV-1) && state==IDLE, registered. Ticks falling during a load are dropped, not deferred.
- Mid-load reset: all state clears asynchronously. Coefficients already written to the FIR remain; the host must restart the load. No partial-load recovery.
- Widths: beat counter 6 bits; no arithmetic on data (pass-through).

## Timing
- Reset values:
  - oCoeffReady, oCoeffUpdateFlag, oEnSample600k, oBusy, oDone = 0
  - oAddrRam = 0, oWrDtRam = 0
  - divider = 0
  - oNumOfCoeff = NUM_COEFF always
- Divider: first tick in the cycle following the DIV-th rising edge after reset release, then every DIV cycles.
- iStart sampled at edge k:
  - after edge k: flag=1, oBusy=1 (ARM)
  - after edge k+1: oCoeffReady=1
- Beat accepted at edge m: the new addr/data are visible after edge m. Minimum load time is therefore 1 + NUM_COEFF + DRAIN_CYC cycles with back-to-back valid.
- Last beat accepted at edge m:
  - ready=0 after edge m
  - flag=0 and oDone=1 after edge m+DRAIN_CYC
  - oDone=0 after the next edge
- iStart coincident with a tick in IDLE: the tick is still issued; ARM begins on the next edge.
- Next iStart is honored in the oDone cycle (state is IDLE).

## Test plan
- Reset release, no start -> all outputs 0, oNumOfCoeff=40; oEnSample600k pulses 1 cycle every 20 cycles, first pulse 20 cycles after release.
- iStart, then 40 back-to-back beats with data 0x1000+i -> oAddrRam steps 0..39 with oWrDtRam 0x1000..0x1027; flag high exactly 43 cycles; oDone single pulse; zero ticks while oBusy.
- Valid asserted every third cycle, 40 beats -> addr/data hold between beats; all 40 addresses written once in order; flag drops 2 cycles after beat 39.
- iStart repeated during LOAD -> ignored, exactly one oDone. Separately, iStart in the tick cycle -> tick emitted, ARM on the next edge.
- iRsn low after 17 beats -> flag, ready, busy and addr go to 0 immediately; after release, iStart plus 40 beats reloads starting at addr 0.
- iCoeffValid=1 in IDLE with no iStart -> oCoeffReady=0, addr/data unchanged, ticks continue.
